// File: rtl/canonical_term_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : canonical_term_engine_if
// Purpose  : Bundles the table-load, evaluation and term-stream signals of
//            canonical_term_engine. The engine connects through the slave
//            modport. The table/stimulus driver connects through the master
//            modport.
// Signals  : tt_load/tt_data        truth-table load
//            in_valid/in_vec        evaluation request
//            f_out/f_valid          registered evaluation result
//            start/mode             sweep control (mode 0 = minterms, 1 = maxterms)
//            term_valid/ready/idx/last/count   term stream
//            busy/done              sweep status
//            dc_mask/f_dc           don't-care mask and result (CTE_DONT_CARE_EN)
// Macro    : CTE_DONT_CARE_EN adds dc_mask and f_dc
// Revision : 1.0 - initial release
// ============================================================================
interface canonical_term_engine_if #(
    parameter int N_IN = 4
);
    localparam int TT_W = 1 << N_IN;

    logic            tt_load;
    logic [TT_W-1:0] tt_data;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            f_out;
    logic            f_valid;
    logic            start;
    logic            mode;
    logic            term_valid;
    logic            term_ready;
    logic [N_IN-1:0] term_idx;
    logic            term_last;
    logic [N_IN:0]   term_count;
    logic            busy;
    logic            done;
`ifdef CTE_DONT_CARE_EN
    logic [TT_W-1:0] dc_mask;
    logic            f_dc;
`endif

    modport slave (
        input  tt_load, tt_data, in_valid, in_vec, start, mode, term_ready,
        output f_out, f_valid, term_valid, term_idx, term_last, term_count,
               busy, done
`ifdef CTE_DONT_CARE_EN
        , input dc_mask, output f_dc
`endif
    );

    modport master (
        output tt_load, tt_data, in_valid, in_vec, start, mode, term_ready,
        input  f_out, f_valid, term_valid, term_idx, term_last, term_count,
               busy, done
`ifdef CTE_DONT_CARE_EN
        , output dc_mask, input f_dc
`endif
    );
endinterface
`default_nettype wire

// File: rtl/canonical_term_engine.sv
`default_nettype none
// ============================================================================
// Module   : canonical_term_engine
// Purpose  : N_IN-input boolean function unit built around a 2**N_IN-bit
//            truth table. It evaluates f(in_vec) with a registered output.
//            In sweep mode it streams every minterm index (mode 0) or every
//            maxterm index (mode 1) over a valid/ready port.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            bus        canonical_term_engine_if.slave (see interface header)
// Params   : N_IN       number of inputs, 2..6
// Macro    : CTE_DONT_CARE_EN enables the don't-care mask. Masked indices are
//            never emitted or counted. f_dc reports the mask bit of the
//            evaluated vector.
// Revision : 1.0 - initial release
// ============================================================================
module canonical_term_engine #(
    parameter int N_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    canonical_term_engine_if.slave  bus
);
    localparam int TT_W = 1 << N_IN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TT_W-1:0] tt_q;
    logic [N_IN-1:0] idx_q, idx_d;
    logic            mode_q, mode_d;
    logic [N_IN:0]   count_q, count_d;
    logic            f_q;
    logic            f_valid_q;

    logic [TT_W-1:0] care;
    logic [TT_W-1:0] match_vec;
    logic [TT_W-1:0] match_above;
    logic            match;
    logic            last;

    // The table is locked while a sweep is running so the stream stays
    // consistent with the table that was present at start.
    wire load_ok = bus.tt_load && (state_q != ST_SCAN);

`ifdef CTE_DONT_CARE_EN
    logic [TT_W-1:0] dc_q;
    logic            f_dc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q   <= '0;
            f_dc_q <= 1'b0;
        end else begin
            if (load_ok)
                dc_q <= bus.dc_mask;
            if (bus.in_valid)
                f_dc_q <= dc_q[bus.in_vec];
        end
    end

    assign care     = ~dc_q;
    assign bus.f_dc = f_dc_q;
`else
    assign care = '1;
`endif

    // Table register and evaluation path. The evaluation reads tt_q before
    // any load on the same edge, so a coincident load uses the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q      <= '0;
            f_q       <= 1'b0;
            f_valid_q <= 1'b0;
        end else begin
            if (load_ok)
                tt_q <= bus.tt_data;
            f_valid_q <= bus.in_valid;
            if (bus.in_valid)
                f_q <= tt_q[bus.in_vec];
        end
    end

    // tt[k] == ~mode  <=>  tt[k] ^ mode == 1
    assign match_vec   = care & (tt_q ^ {TT_W{mode_q}});
    assign match       = match_vec[idx_q];
    assign match_above = (match_vec >> idx_q) >> 1;
    assign last        = match && (match_above == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    mode_d  = bus.mode;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            ST_SCAN: begin
                // A matching index stays put until the consumer takes it.
                if (!match || bus.term_ready) begin
                    if (match)
                        count_d = count_q + 1'b1;
                    if (&idx_q)
                        state_d = ST_DONE;
                    else
                        idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.f_out      = f_q;
    assign bus.f_valid    = f_valid_q;
    assign bus.term_valid = (state_q == ST_SCAN) && match;
    assign bus.term_last  = (state_q == ST_SCAN) && last;
    assign bus.term_idx   = idx_q;
    assign bus.term_count = count_q;
    assign bus.busy       = (state_q == ST_SCAN);
    assign bus.done       = (state_q == ST_DONE);

endmodule
`default_nettype wire
